// File: rtl/timer_pkg.sv
// Shared definitions for the reload timer: register offsets, TCON bit layout
// and a helper that maps a bus word index onto a register select.
package timer_pkg;

  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_TCON = 4'h8;
  localparam logic [3:0] OFF_PSC  = 4'hC;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_IS      = 2;
  localparam int TCON_ONESHOT = 3;

  typedef enum logic [1:0] {
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_PSC
  } reg_sel_e;

  // Word index is addr[3:2]; byte lanes within a word are ignored.
  function automatic reg_sel_e decode_offset(input logic [1:0] word_idx);
    logic [3:0] aligned;
    aligned = {word_idx, 2'b00};
    case (aligned)
      OFF_TH:   return REG_TH;
      OFF_TL:   return REG_TL;
      OFF_TCON: return REG_TCON;
      default:  return REG_PSC;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..psc while enabled and emits a one-cycle tick on the
// terminal count. A bus write to TL or PSC restarts the count at zero.
module timer_prescaler #(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PSC_WIDTH-1:0] psc,
  output logic                 tick
);

  logic [PSC_WIDTH-1:0] r_count;

  // Tick is taken from the pre-edge count so it lines up with the TL update.
  assign tick = en && (r_count == psc);

  // Count advances while enabled; disable, clear or terminal count return it to 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr || !en || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PSC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped reload timer: bus decode, TH/TL/TCON/PSC registers, TL
// counter with reload from TH, and the interrupt status / pulse logic.
module timer_irq_unit
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PSC_WIDTH = 16
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memwrite,
  input  logic        memread,
  output logic [31:0] rdata,
  output logic        irqout,
  output logic        irq_pulse
);

  logic [31:0]          r_th;
  logic [31:0]          r_tl;
  logic [3:0]           r_tcon;
  logic [PSC_WIDTH-1:0] r_psc;
  logic                 r_irq_pulse;

  logic     w_hit;
  reg_sel_e w_sel;
  logic     w_wr_th;
  logic     w_wr_tl;
  logic     w_wr_tcon;
  logic     w_wr_psc;
  logic     w_tick;
  logic     w_overflow;
  logic     w_irq_set;
  logic [3:0] w_tcon_next;
  logic     w_unused_addr;

  // Byte-lane bits carry no meaning for word registers.
  assign w_unused_addr = ^addr[1:0];

  assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_sel     = decode_offset(addr[3:2]);
  assign w_wr_th   = memwrite && w_hit && (w_sel == REG_TH);
  assign w_wr_tl   = memwrite && w_hit && (w_sel == REG_TL);
  assign w_wr_tcon = memwrite && w_hit && (w_sel == REG_TCON);
  assign w_wr_psc  = memwrite && w_hit && (w_sel == REG_PSC);

  timer_prescaler #(
    .PSC_WIDTH(PSC_WIDTH)
  ) u_prescaler (
    .sysclk (sysclk),
    .reset  (reset),
    .en     (r_tcon[TCON_EN]),
    .clr    (w_wr_tl || w_wr_psc),
    .psc    (r_psc),
    .tick   (w_tick)
  );

  assign w_overflow = w_tick && (r_tl == 32'hFFFF_FFFF);
  assign w_irq_set  = w_overflow && r_tcon[TCON_IE];

  // TH/PSC are plain bus registers; TL counts on tick, reloads from the old TH
  // on overflow, and a bus write to TL overrides both.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_th  <= '0;
      r_tl  <= '0;
      r_psc <= '0;
    end else begin
      if (w_wr_th) begin
        r_th <= wdata;
      end
      if (w_wr_psc) begin
        r_psc <= wdata[PSC_WIDTH-1:0];
      end
      if (w_wr_tl) begin
        r_tl <= wdata;
      end else if (w_tick) begin
        r_tl <= w_overflow ? r_th : r_tl + 32'd1;
      end
    end
  end

  // Next TCON: bus write (IS is write-0-to-clear), then overflow effects on top.
  // NOTE: start from a full default so no path leaves the value unassigned (no latch).
  always_comb begin
    w_tcon_next = r_tcon;
    if (w_wr_tcon) begin
      w_tcon_next          = wdata[3:0];
      w_tcon_next[TCON_IS] = r_tcon[TCON_IS] & wdata[TCON_IS];
    end
    if (w_irq_set) begin
      w_tcon_next[TCON_IS] = 1'b1;
    end
    if (w_overflow && r_tcon[TCON_ONESHOT]) begin
      w_tcon_next[TCON_EN] = 1'b0;
    end
  end

  // TCON and the registered one-cycle overflow pulse.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_tcon      <= '0;
      r_irq_pulse <= 1'b0;
    end else begin
      r_tcon      <= w_tcon_next;
      r_irq_pulse <= w_irq_set;
    end
  end

  // Zero-latency read mux; anything outside the window reads as 0.
  always_comb begin
    rdata = '0;
    if (memread && w_hit) begin
      case (w_sel)
        REG_TH:   rdata = r_th;
        REG_TL:   rdata = r_tl;
        REG_TCON: rdata = {28'd0, r_tcon};
        default:  rdata = 32'(r_psc);
      endcase
    end
  end

  assign irqout    = r_tcon[TCON_IS];
  assign irq_pulse = r_irq_pulse;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Self-checking bench for timer_irq_unit: directed scenarios plus a random
// run compared against a behavioural register-level model.
module tb_timer_irq_unit;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] rdata;
  logic        irqout;
  logic        irq_pulse;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state (post-edge view of the peripheral).
  logic [31:0] m_th, m_tl;
  int unsigned m_psc, m_cnt;
  bit          m_en, m_ie, m_is, m_os, m_pulse;

  timer_irq_unit #(
    .BASE_ADDR(BASE),
    .PSC_WIDTH(16)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .memwrite  (memwrite),
    .memread   (memread),
    .rdata     (rdata),
    .irqout    (irqout),
    .irq_pulse (irq_pulse)
  );

  always #5 sysclk = ~sysclk;

  // Advance the model across one clock edge using the rules of the peripheral.
  task automatic model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic rst);
    bit hit, tick, ovf;
    int unsigned idx;
    if (rst) begin
      m_th = 0; m_tl = 0; m_psc = 0; m_cnt = 0;
      m_en = 0; m_ie = 0; m_is = 0; m_os = 0; m_pulse = 0;
      return;
    end
    hit  = wr && (a[31:4] == BASE[31:4]);
    idx  = a[3:2];
    tick = m_en && (m_cnt == m_psc);
    ovf  = tick && (m_tl == 32'hFFFF_FFFF);
    m_pulse = ovf && m_ie;
    // Prescaler: cycles 0..PSC while enabled, restart on TL/PSC write.
    if (hit && (idx == 1 || idx == 3)) m_cnt = 0;
    else if (!m_en) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % (m_psc + 1);
    // TL: written value wins, else count / reload from pre-edge TH.
    if (hit && idx == 1) m_tl = d;
    else if (tick) m_tl = ovf ? m_th : m_tl + 1;
    if (hit && idx == 0) m_th = d;
    if (hit && idx == 3) m_psc = d[15:0];
    if (hit && idx == 2) begin
      m_is = m_is && d[2];
      m_en = d[0]; m_ie = d[1]; m_os = d[3];
    end
    if (ovf && m_pulse) m_is = 1;
    if (ovf && m_os_pre(m_os, hit && idx == 2, d)) m_en = 0;
  endtask

  // ONESHOT that applies to an overflow is the value held before the edge.
  bit m_os_snap;
  function automatic bit m_os_pre(input bit cur, input bit wrote, input logic [31:0] d);
    return wrote ? m_os_snap : cur;
  endfunction

  function automatic logic [31:0] model_reg(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return m_th;
      2'd1:    return m_tl;
      2'd2:    return {28'd0, m_os, m_is, m_ie, m_en};
      default: return 32'(m_psc);
    endcase
  endfunction

  task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic rst);
    memwrite = wr; addr = a; wdata = d; reset = rst; memread = 1'b0;
    m_os_snap = m_os;
    model_edge(wr, a, d, rst);
    @(posedge sysclk);
    #1;
    memwrite = 1'b0; reset = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    step(1'b1, BASE + off, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; memread = 1'b1;
    #1;
    v = rdata;
    memread = 1'b0; addr = '0;
  endtask

  task automatic quiesce();
    wr(32'h8, 32'h0);
    wr(32'h8, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    step(1'b0, 32'd0, 32'd0, 1'b1);
    if (irqout !== 1'b0) begin $display("FAIL reset_irqout got=%b exp=0", irqout); n_fails++; end
    n_checks++;
    if (irq_pulse !== 1'b0) begin $display("FAIL reset_pulse got=%b exp=0", irq_pulse); n_fails++; end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      bus_read(BASE + 32'(i * 4), v);
      if (v !== 32'd0) begin $display("FAIL reset_reg%0d got=%h exp=0", i, v); n_fails++; end
      n_checks++;
    end
  endtask

  task automatic test_overflow_reload();
    logic [31:0] v;
    quiesce();
    wr(32'h0, 32'hFFFF_FFFD); wr(32'h4, 32'hFFFF_FFFE); wr(32'hC, 32'h0); wr(32'h8, 32'h3);
    idle();
    bus_read(BASE + 4, v);
    if (v !== 32'hFFFF_FFFF) begin $display("FAIL ovf_tl1 got=%h exp=ffffffff", v); n_fails++; end
    n_checks++;
    if (irq_pulse !== 1'b0) begin $display("FAIL ovf_pulse_early got=%b exp=0", irq_pulse); n_fails++; end
    n_checks++;
    idle();
    bus_read(BASE + 4, v);
    if (v !== 32'hFFFF_FFFD) begin $display("FAIL ovf_reload got=%h exp=fffffffd", v); n_fails++; end
    n_checks++;
    if (irq_pulse !== 1'b1) begin $display("FAIL ovf_pulse got=%b exp=1", irq_pulse); n_fails++; end
    n_checks++;
    if (irqout !== 1'b1) begin $display("FAIL ovf_irqout got=%b exp=1", irqout); n_fails++; end
    n_checks++;
    idle();
    if (irq_pulse !== 1'b0) begin $display("FAIL ovf_pulse_width got=%b exp=0", irq_pulse); n_fails++; end
    n_checks++;
    if (irqout !== 1'b1) begin $display("FAIL ovf_irqout_level got=%b exp=1", irqout); n_fails++; end
    n_checks++;
  endtask

  task automatic test_prescaler();
    logic [31:0] v;
    quiesce();
    wr(32'hC, 32'd3); wr(32'h4, 32'd0); wr(32'h8, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle();
      bus_read(BASE + 4, v);
      if (v !== 32'(k / 4)) begin $display("FAIL psc_tl k=%0d got=%h exp=%h", k, v, k / 4); n_fails++; end
      n_checks++;
    end
  endtask

  task automatic test_is_clear_race();
    logic [31:0] v;
    quiesce();
    wr(32'hC, 32'h0); wr(32'h0, 32'hFFFF_FFFF); wr(32'h4, 32'hFFFF_FFFF); wr(32'h8, 32'h3);
    idle();
    if (irqout !== 1'b1) begin $display("FAIL race_setup got=%b exp=1", irqout); n_fails++; end
    n_checks++;
    wr(32'h8, 32'h3);
    if (irqout !== 1'b1) begin $display("FAIL race_set_wins got=%b exp=1", irqout); n_fails++; end
    n_checks++;
    wr(32'h0, 32'h0);
    bus_read(BASE + 4, v);
    if (v !== 32'hFFFF_FFFF) begin $display("FAIL race_old_th got=%h exp=ffffffff", v); n_fails++; end
    n_checks++;
    idle();
    bus_read(BASE + 4, v);
    if (v !== 32'h0) begin $display("FAIL race_new_th got=%h exp=0", v); n_fails++; end
    n_checks++;
    wr(32'h8, 32'h3);
    if (irqout !== 1'b0) begin $display("FAIL race_clear got=%b exp=0", irqout); n_fails++; end
    n_checks++;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    int bad;
    quiesce();
    wr(32'hC, 32'h0); wr(32'h0, 32'h10); wr(32'h4, 32'hFFFF_FFFF); wr(32'h8, 32'hB);
    idle();
    bus_read(BASE + 4, v);
    if (v !== 32'h10) begin $display("FAIL oneshot_tl got=%h exp=10", v); n_fails++; end
    n_checks++;
    bus_read(BASE + 8, v);
    if (v !== 32'hE) begin $display("FAIL oneshot_tcon got=%h exp=e", v); n_fails++; end
    n_checks++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      bus_read(BASE + 4, v);
      if (v !== 32'h10) bad++;
    end
    if (bad != 0) begin $display("FAIL oneshot_hold got=%0d_moves exp=0", bad); n_fails++; end
    n_checks++;
  endtask

  task automatic test_tl_write_window();
    logic [31:0] v;
    quiesce();
    wr(32'hC, 32'h0); wr(32'h4, 32'h0); wr(32'h8, 32'h1);
    idle(); idle();
    wr(32'h4, 32'h1234);
    bus_read(BASE + 4, v);
    if (v !== 32'h1234) begin $display("FAIL tlwr_beats_tick got=%h exp=1234", v); n_fails++; end
    n_checks++;
    idle();
    bus_read(BASE + 4, v);
    if (v !== 32'h1235) begin $display("FAIL tlwr_next got=%h exp=1235", v); n_fails++; end
    n_checks++;
    wr(32'h10, 32'hCAFE_0000);
    bus_read(BASE + 32'h10, v);
    if (v !== 32'h0) begin $display("FAIL read_off10 got=%h exp=0", v); n_fails++; end
    n_checks++;
    bus_read(BASE, v);
    if (v !== model_reg(BASE)) begin $display("FAIL off10_write_th got=%h exp=%h", v, model_reg(BASE)); n_fails++; end
    n_checks++;
    addr = BASE + 4; memread = 1'b0;
    #1;
    if (rdata !== 32'h0) begin $display("FAIL read_noen got=%h exp=0", rdata); n_fails++; end
    n_checks++;
    addr = '0;
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] v;
    quiesce();
    wr(32'h0, 32'h0); wr(32'hC, 32'h0); wr(32'h4, 32'hFFFF_FFFF); wr(32'h8, 32'h3);
    idle();
    wr(32'hC, 32'h2); wr(32'h8, 32'h7);
    idle(); idle();
    if (irqout !== 1'b1) begin $display("FAIL rst_pre_irqout got=%b exp=1", irqout); n_fails++; end
    n_checks++;
    step(1'b1, BASE, 32'hDEAD_BEEF, 1'b1);
    if (irqout !== 1'b0) begin $display("FAIL rst_irqout got=%b exp=0", irqout); n_fails++; end
    n_checks++;
    bus_read(BASE, v);
    if (v !== 32'h0) begin $display("FAIL rst_th got=%h exp=0", v); n_fails++; end
    n_checks++;
    bus_read(BASE + 4, v);
    if (v !== 32'h0) begin $display("FAIL rst_tl got=%h exp=0", v); n_fails++; end
    n_checks++;
    bus_read(BASE + 8, v);
    if (v !== 32'h0) begin $display("FAIL rst_tcon got=%h exp=0", v); n_fails++; end
    n_checks++;
    idle();
    bus_read(BASE + 12, v);
    if (v !== 32'h0) begin $display("FAIL rst_psc got=%h exp=0", v); n_fails++; end
    n_checks++;
  endtask

  task automatic test_random();
    logic [31:0] v, a, d, exp_v;
    int op;
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 11));
      d  = $urandom;
      a  = 32'd0;
      if ($urandom_range(0, 63) == 0) begin
        step(1'b0, 32'd0, 32'd0, 1'b1);
      end else begin
        case (op)
          0: begin a = BASE;        if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | $urandom_range(0, 15); end
          1: begin a = BASE + 4;    if ($urandom_range(0, 3) != 0) d = 32'hFFFF_FFF0 | $urandom_range(0, 15); end
          2: begin a = BASE + 8;    d = $urandom_range(0, 15); if ($urandom_range(0, 1) == 1) d[0] = 1'b1; end
          3: begin a = BASE + 12;   d = $urandom_range(0, 3); end
          4: begin a = BASE + 32'h10 + 32'($urandom_range(0, 3) * 4); end
          default: a = 32'd0;
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
        step(op <= 4, a, d, 1'b0);
      end
      if (irqout !== m_is) begin $display("FAIL rnd_irqout i=%0d got=%b exp=%b", i, irqout, m_is); n_fails++; end
      n_checks++;
      if (irq_pulse !== m_pulse) begin $display("FAIL rnd_pulse i=%0d got=%b exp=%b", i, irq_pulse, m_pulse); n_fails++; end
      n_checks++;
      a = BASE + 32'($urandom_range(0, 4) * 4);
      exp_v = model_reg(a);
      bus_read(a, v);
      if (v !== exp_v) begin $display("FAIL rnd_read i=%0d addr=%h got=%h exp=%h", i, a, v, exp_v); n_fails++; end
      n_checks++;
    end
  endtask

  initial begin
    m_os_snap = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    test_reset();
    test_overflow_reload();
    test_prescaler();
    test_is_clear_race();
    test_oneshot();
    test_tl_write_window();
    test_reset_mid_count();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
